// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences the shared datapath through the
// per-instruction state paths and counts retired instructions.
module multi_cycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op_code,
   input  logic [5:0]       funct,
   input  logic             zf,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             ext_zero,
   output logic [3:0]       alu_op,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_retired
);

   typedef enum logic [3:0] {
      S_IF    = 4'd0,  S_ID  = 4'd1,  S_EXR = 4'd2,  S_WBR = 4'd3,
      S_EXI   = 4'd4,  S_WBI = 4'd5,  S_MADDR = 4'd6, S_MRD = 4'd7,
      S_MWB   = 4'd8,  S_MWR = 4'd9,  S_BEQ = 4'd10, S_JMP = 4'd11,
      S_ILL   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                          OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LW = 6'b100011,
                          OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;

   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                          ALU_XOR = 4'b0011, ALU_SLL = 4'b0100, ALU_SUB = 4'b0110,
                          ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;

   // Supported R-type function codes; anything else traps to ILL from ID.
   function automatic logic rtype_ok(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101,
         6'b100110, 6'b100111, 6'b101010, 6'b000000: rtype_ok = 1'b1;
         default:                                    rtype_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100010: rtype_alu = ALU_SUB;
         6'b100100: rtype_alu = ALU_AND;
         6'b100101: rtype_alu = ALU_OR;
         6'b100110: rtype_alu = ALU_XOR;
         6'b100111: rtype_alu = ALU_NOR;
         6'b101010: rtype_alu = ALU_SLT;
         6'b000000: rtype_alu = ALU_SLL;
         default:   rtype_alu = ALU_ADD;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               retire_s;

   // Next-state and datapath control decode.
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_zero   = 1'b0;
      alu_op     = ALU_ADD;
      illegal    = 1'b0;
      case (state_q)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_ID;
            end else begin
               state_d  = S_IF;
            end
         end
         S_ID: begin
            alu_src_b = 2'b11;
            case (op_code)
               OP_R: begin
                  if (rtype_ok(funct)) begin
                     state_d = S_EXR;
                  end else begin
                     state_d = S_ILL;
                  end
               end
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXI;
               OP_LW, OP_SW:                      state_d = S_MADDR;
               OP_BEQ:                            state_d = S_BEQ;
               OP_J:                              state_d = S_JMP;
               default:                           state_d = S_ILL;
            endcase
         end
         S_EXR: begin
            alu_src_a = 1'b1;
            alu_op    = rtype_alu(funct);
            state_d   = S_WBR;
         end
         S_WBR: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_IF;
         end
         S_EXI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (op_code)
               OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
               OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
               OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
               default: alu_op = ALU_ADD;
            endcase
            state_d = S_WBI;
         end
         S_WBI: begin
            reg_write = 1'b1;
            state_d   = S_IF;
         end
         S_MADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (op_code == OP_LW) begin
               state_d = S_MRD;
            end else begin
               state_d = S_MWR;
            end
         end
         S_MRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_MWB;
            end else begin
               state_d = S_MRD;
            end
         end
         S_MWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_IF;
         end
         S_MWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               state_d = S_IF;
            end else begin
               state_d = S_MWR;
            end
         end
         S_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_write  = zf;
            state_d   = S_IF;
         end
         S_JMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_IF;
         end
         S_ILL: begin
            illegal = 1'b1;
            state_d = S_ILL;
         end
         // Unreachable encodings are treated as a fault and halt.
         default: begin
            illegal = 1'b1;
            state_d = S_ILL;
         end
      endcase
   end

   // An instruction retires on the edge that returns a completed path to IF.
   always_comb begin
      case (state_q)
         S_WBR, S_WBI, S_MWB, S_BEQ, S_JMP: retire_s = 1'b1;
         S_MWR:                             retire_s = mem_ready;
         default:                           retire_s = 1'b0;
      endcase
   end

   // State register and retired-instruction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (retire_s) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_q <= cnt_q;
         end
      end
   end

   assign state         = state_q;
   assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected state, controls
// and retired count are queued as stimulus is applied and popped for compare.
module tb_multi_cycle_ctrl;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst, zf, mem_ready;
   logic [5:0]       op_code, funct;
   logic             pc_write, iord, mem_read, mem_write, ir_write, reg_write;
   logic             reg_dst, mem_to_reg, alu_src_a, ext_zero, illegal;
   logic [1:0]       pc_src, alu_src_b;
   logic [3:0]       alu_op, state;
   logic [CNT_W-1:0] instr_retired;

   typedef struct packed {
      logic [3:0]       st;
      logic [18:0]      ov;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t             sb[$];
   exp_t             e;
   logic [CNT_W-1:0] exp_cnt;
   logic             last_ret;
   int               checks = 0;
   int               errors = 0;
   logic [18:0]      dut_ov;
   exp_t             dut_obs;

   multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .zf(zf),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
      .alu_op(alu_op), .state(state), .illegal(illegal),
      .instr_retired(instr_retired)
   );

   always #5 clk = ~clk;

   assign dut_ov  = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, illegal};
   assign dut_obs = '{st: state, ov: dut_ov, cnt: instr_retired};

   // Reference control table, written from the per-state output list.
   function automatic logic [18:0] model(input logic [3:0] s, input logic mr, input logic z,
                                         input logic [5:0] op, input logic [5:0] fn);
      logic pcw, io, mrd, mwr, irw, rw, rd, m2r, asa, ez, ill;
      logic [1:0] pcs, asb;
      logic [3:0] aop;
      {pcw, io, mrd, mwr, irw, rw, rd, m2r, asa, ez, ill} = 11'd0;
      pcs = 2'b00; asb = 2'b00; aop = 4'b0010;
      case (s)
         4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
         4'd1:  asb = 2'b11;
         4'd2:  begin
            asa = 1'b1;
            case (fn)
               6'b100010: aop = 4'b0110;
               6'b100100: aop = 4'b0000;
               6'b100101: aop = 4'b0001;
               6'b100110: aop = 4'b0011;
               6'b100111: aop = 4'b1100;
               6'b101010: aop = 4'b0111;
               6'b000000: aop = 4'b0100;
               default:   aop = 4'b0010;
            endcase
         end
         4'd3:  begin rw = 1'b1; rd = 1'b1; end
         4'd4:  begin
            asa = 1'b1; asb = 2'b10;
            if (op == 6'b001100)      begin aop = 4'b0000; ez = 1'b1; end
            else if (op == 6'b001101) begin aop = 4'b0001; ez = 1'b1; end
            else if (op == 6'b001110) begin aop = 4'b0011; ez = 1'b1; end
            else                            aop = 4'b0010;
         end
         4'd5:  rw = 1'b1;
         4'd6:  begin asa = 1'b1; asb = 2'b10; end
         4'd7:  begin mrd = 1'b1; io = 1'b1; end
         4'd8:  begin rw = 1'b1; m2r = 1'b1; end
         4'd9:  begin mwr = 1'b1; io = 1'b1; end
         4'd10: begin asa = 1'b1; aop = 4'b0110; pcs = 2'b01; pcw = z; end
         4'd11: begin pcw = 1'b1; pcs = 2'b10; end
         4'd12: ill = 1'b1;
         default: ill = 1'b1;
      endcase
      return {pcw, pcs, io, mrd, mwr, irw, rw, rd, m2r, asa, asb, ez, aop, ill};
   endfunction

   task automatic push_step(input logic mr, input logic [3:0] es);
      exp_t x;
      mem_ready = mr;
      x.st  = es;
      x.ov  = model(es, mr, zf, op_code, funct);
      x.cnt = exp_cnt;
      sb.push_back(x);
      last_ret = (es == 4'd3) || (es == 4'd5) || (es == 4'd8) || (es == 4'd10) ||
                 (es == 4'd11) || ((es == 4'd9) && mr);
   endtask

   task automatic tick();
      @(posedge clk);
      if (last_ret) exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b0; zf = 1'b0; op_code = 6'd0; funct = 6'd0;
      exp_cnt = '0;
      #1;
      checks++;
      if (dut_obs !== exp_t'({4'd0, 19'b0_00_0_1_0_0_0_0_0_0_01_0_0010_0, 4'd0})) begin
         errors++;
         $display("FAIL reset: got %h expected %h", dut_obs,
                  exp_t'({4'd0, 19'b0_00_0_1_0_0_0_0_0_0_01_0_0010_0, 4'd0}));
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_rtype_add();
      logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      op_code = 6'b000000; funct = 6'b100000;
      for (int i = 0; i < 5; i++) begin
         push_step(1'b1, st[i]); #2; e = sb.pop_front(); checks++;
         if (dut_obs !== e) begin errors++; $display("FAIL add c%0d: got %h expected %h", i, dut_obs, e); end
         if (i < 4) tick();
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0] st [11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd7, 4'd7, 4'd8, 4'd0};
      logic       mr [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      op_code = 6'b100011;
      for (int i = 0; i < 11; i++) begin
         push_step(mr[i], st[i]); #2; e = sb.pop_front(); checks++;
         if (dut_obs !== e) begin errors++; $display("FAIL lw c%0d: got %h expected %h", i, dut_obs, e); end
         if (i < 10) tick();
      end
   endtask

   task automatic test_beq();
      logic [3:0] st [3] = '{4'd0, 4'd1, 4'd10};
      op_code = 6'b000100;
      for (int k = 0; k < 2; k++) begin
         zf = (k == 0);
         for (int i = 0; i < 3; i++) begin
            push_step(1'b1, st[i]); #2; e = sb.pop_front(); checks++;
            if (dut_obs !== e) begin errors++; $display("FAIL beq z%0d c%0d: got %h expected %h", zf, i, dut_obs, e); end
            tick();
         end
      end
      zf = 1'b0;
   endtask

   task automatic test_ori();
      logic [3:0] st [5] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd0};
      op_code = 6'b001101;
      for (int i = 0; i < 5; i++) begin
         push_step(1'b1, st[i]); #2; e = sb.pop_front(); checks++;
         if (dut_obs !== e) begin errors++; $display("FAIL ori c%0d: got %h expected %h", i, dut_obs, e); end
         if (i < 4) tick();
      end
   endtask

   task automatic test_illegal();
      logic [3:0] st [6] = '{4'd0, 4'd1, 4'd12, 4'd12, 4'd12, 4'd12};
      logic       mr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         op_code = (k == 0) ? 6'b111111 : 6'b000000;
         funct   = 6'b001000;
         for (int i = 0; i < 6; i++) begin
            push_step(mr[i], st[i]); #2; e = sb.pop_front(); checks++;
            if (dut_obs !== e) begin errors++; $display("FAIL ill%0d c%0d: got %h expected %h", k, i, dut_obs, e); end
            tick();
         end
         rst = 1'b1; exp_cnt = '0; #1;
         checks++;
         if (state !== 4'd0 || illegal !== 1'b0 || instr_retired !== 4'd0) begin
            errors++;
            $display("FAIL ill%0d_rst: got st=%0d ill=%b cnt=%0d expected st=0 ill=0 cnt=0", k, state, illegal, instr_retired);
         end
         @(negedge clk); rst = 1'b0;
      end
   endtask

   task automatic test_rst_mid_mwr();
      logic [3:0] st [5] = '{4'd0, 4'd1, 4'd6, 4'd9, 4'd9};
      logic       mr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      op_code = 6'b000010;
      push_step(1'b1, 4'd0); #2; e = sb.pop_front(); tick();
      push_step(1'b0, 4'd1); #2; e = sb.pop_front(); tick();
      push_step(1'b0, 4'd11); #2; e = sb.pop_front(); tick();
      op_code = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         push_step(mr[i], st[i]); #2; e = sb.pop_front(); checks++;
         if (dut_obs !== e) begin errors++; $display("FAIL sw c%0d: got %h expected %h", i, dut_obs, e); end
         if (i < 4) tick();
      end
      rst = 1'b1; exp_cnt = '0; #1;
      checks++;
      if (mem_write !== 1'b0 || state !== 4'd0 || instr_retired !== 4'd0) begin
         errors++;
         $display("FAIL sw_rst: got mw=%b st=%0d cnt=%0d expected mw=0 st=0 cnt=0", mem_write, state, instr_retired);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_counter_wrap();
      logic [3:0] st [3] = '{4'd0, 4'd1, 4'd11};
      op_code = 6'b000010;
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < 3; i++) begin
            push_step(1'b1, st[i]); #2; e = sb.pop_front(); checks++;
            if (dut_obs !== e) begin errors++; $display("FAIL j%0d c%0d: got %h expected %h", n, i, dut_obs, e); end
            tick();
         end
      end
      #2; checks++;
      if (instr_retired !== 4'd0 || state !== 4'd0) begin
         errors++;
         $display("FAIL wrap: got cnt=%0d st=%0d expected cnt=0 st=0", instr_retired, state);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
      end
   endtask

   initial begin
      last_ret = 1'b0;
      test_reset();
      test_rtype_add();
      test_lw_wait();
      test_beq();
      test_ori();
      test_illegal();
      test_rst_mid_mwr();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
